pipe_ctrl_stage: RTL and testbench
==================================

// Module: pipe_ctrl_stage
// PURPOSE
//  Parametrised control-field pipeline register for the 5-stage RV32 core.
//  Carries per-instruction control bits (RegWrite, MemWrite, ResultSrc, ...) through DEPTH stages.
//  Adds what the fixed inter-stage registers lack:
//   - valid tracking, global stall (hold) and synchronous flush (bubble)
//   - masking of side-effecting bits on bubbles, and an occupancy count
//  Instantiated between EX/MEM/WB for control paths; one instance per boundary or one multi-stage span.
// PARAMETERS
//  WIDTH     4        control-field width in bits (>=1)
//  DEPTH     1        number of register stages, latency in cycles (>=1)
//  SIDE_MASK 4'b0011  bits forced to 0 whenever a stage holds a bubble (valid=0); WIDTH bits
// PORTS
//  clk       in   1             clock, rising edge
//  reset     in   1             asynchronous, active-low reset
//  stall_i   in   1             hold all stages this cycle
//  flush_i   in   1             turn all stages into bubbles this cycle
//  valid_i   in   1             ctrl_i carries a real instruction
//  ctrl_i    in   WIDTH         control field entering stage 0
//  inj_i     in   1             parity error inject (only used with PIPE_CTRL_PARITY_EN)
//  valid_o   out  1             valid of last stage
//  ctrl_o    out  WIDTH         control field of last stage
//  occ_o     out  $clog2(DEPTH+1)  number of stages with valid=1
//  parity_err_o out 1           stored parity mismatch on last stage
// BEHAVIOUR
//  - Reset (reset=0, async): every stage valid=0, ctrl=0; valid_o=0, ctrl_o=0, occ_o=0, parity_err_o=0.
//  - Normal (no stall, no flush), per rising edge:
//     stage0 <= {valid_i, valid_i ? ctrl_i : ctrl_i & ~SIDE_MASK}
//     stage[k] <= stage[k-1] for k=1..DEPTH-1
//  - Latency exactly DEPTH cycles: input sampled at edge n appears on outputs after edge n+DEPTH-1.
//  - Outputs are registered, driven directly from stage DEPTH-1; no combinational input->output path.
//  - stall_i=1: all stages hold value; valid_i/ctrl_i ignored; occ_o unchanged.
//  - flush_i=1: all stages get valid=0 and ctrl &= ~SIDE_MASK (non-masked bits keep their value).
//     - Takes effect next edge.
//     - Flush has priority over stall when both are 1.
//     - Same-cycle valid_i is dropped.
//  - Invariant: whenever a stage has valid=0, its SIDE_MASK bits are 0. A bubble can never write the register file or memory.
//  - occ_o: registered popcount of stage valids; updated in the same edge as the stages. Range 0..DEPTH.
//  - Reset asserted mid-operation: immediate clear of all stages regardless of stall/flush.
//  - Reset release: first edge behaves as Normal.
// CONFIGURATION
//  PIPE_CTRL_PARITY_EN defined:
//   - each stage stores an even-parity bit over its ctrl field; parity is computed at stage0 entry and moves with the data.
//   - inj_i=1 on a loading edge stores the inverted parity in stage0.
//   - parity_err_o = valid_o & (^ctrl_o != stored parity of last stage); registered alongside valid_o.
//   - flush/bubble recompute parity for the masked value.
//  PIPE_CTRL_PARITY_EN undefined:
//   - no parity storage; inj_i ignored; parity_err_o tied to 0.
// TESTING
//  1. Reset: WIDTH=4, DEPTH=1; hold reset=0 with ctrl_i=4'hF, valid_i=1 -> valid_o=0, ctrl_o=0, occ_o=0.
//  2. Latency: DEPTH=3; feed valid 4'hA,4'h5,4'hC on 3 edges -> ctrl_o=A,5,C on edges 3,4,5; occ_o=3 after edge 3.
//  3. Bubble mask: valid_i=0, ctrl_i=4'hF, SIDE_MASK=4'b0011 -> stage holds 4'hC, valid_o=0 after DEPTH edges.
//  4. Stall: DEPTH=2 full (A,5); stall_i=1 for 4 edges with ctrl_i=3 -> outputs/occ_o frozen; release -> 5 then 3.
//  5. Flush+stall: stall_i=1 and flush_i=1 on a full DEPTH=2 pipe of 4'hF -> next edge valid_o=0, ctrl_o=4'hC, occ_o=0.
//  6. Parity (macro on): inj_i=1 with valid 4'h6 -> parity_err_o=1 exactly when it reaches outputs; macro off -> always 0.

Source files
------------

// File: rtl/pipe_ctrl_stage.sv
// Control-field pipeline with valid tracking, stall/flush and bubble masking of side-effecting bits.
// Optional parity per stage when PIPE_CTRL_PARITY_EN is defined.
module pipe_ctrl_stage #(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] SIDE_MASK = WIDTH'(4'b0011),
    localparam int              OCC_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] ctrl_i,
    input  logic             inj_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] ctrl_o,
    output logic [OCC_W-1:0] occ_o,
    output logic             parity_err_o
);

    // Handshake: no ready path; stall_i freezes every stage, flush_i turns every
    // stage into a bubble and wins over stall_i. valid_i is dropped while either is high.
    logic             valid_q [DEPTH];
    logic             valid_d [DEPTH];
    logic [WIDTH-1:0] ctrl_q  [DEPTH];
    logic [WIDTH-1:0] ctrl_d  [DEPTH];
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

`ifdef PIPE_CTRL_PARITY_EN
    logic par_q [DEPTH];
    logic par_d [DEPTH];
`endif

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            valid_d[k] = valid_q[k];
            ctrl_d[k]  = ctrl_q[k];
`ifdef PIPE_CTRL_PARITY_EN
            par_d[k]   = par_q[k];
`endif
        end
        if (flush_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                valid_d[k] = 1'b0;
                ctrl_d[k]  = ctrl_q[k] & ~SIDE_MASK;
`ifdef PIPE_CTRL_PARITY_EN
                par_d[k]   = ^(ctrl_q[k] & ~SIDE_MASK);
`endif
            end
        end else if (!stall_i) begin
            valid_d[0] = valid_i;
            ctrl_d[0]  = valid_i ? ctrl_i : (ctrl_i & ~SIDE_MASK);
`ifdef PIPE_CTRL_PARITY_EN
            par_d[0]   = (^(valid_i ? ctrl_i : (ctrl_i & ~SIDE_MASK))) ^ inj_i;
`endif
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                ctrl_d[k]  = ctrl_q[k-1];
`ifdef PIPE_CTRL_PARITY_EN
                par_d[k]   = par_q[k-1];
`endif
            end
        end
        occ_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + OCC_W'(valid_d[k]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                valid_q[k] <= 1'b0;
                ctrl_q[k]  <= '0;
`ifdef PIPE_CTRL_PARITY_EN
                par_q[k]   <= 1'b0;
`endif
            end
            occ_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                valid_q[k] <= valid_d[k];
                ctrl_q[k]  <= ctrl_d[k];
`ifdef PIPE_CTRL_PARITY_EN
                par_q[k]   <= par_d[k];
`endif
            end
            occ_q <= occ_d;
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign ctrl_o  = ctrl_q[DEPTH-1];
    assign occ_o   = occ_q;

`ifdef PIPE_CTRL_PARITY_EN
    assign parity_err_o = valid_q[DEPTH-1] & ((^ctrl_q[DEPTH-1]) != par_q[DEPTH-1]);
`else
    logic unused_inj;
    assign unused_inj   = inj_i;
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Directed bench for pipe_ctrl_stage: DEPTH=1, 2 and 3 instances share one input stream.
module tb_pipe_ctrl_stage;

  logic       clk;
  logic       reset;
  logic       stall_i;
  logic       flush_i;
  logic       valid_i;
  logic [3:0] ctrl_i;
  logic       inj_i;

  logic       v1, v2, v3;
  logic [3:0] c1, c2, c3;
  logic [0:0] o1;
  logic [1:0] o2, o3;
  logic       e1, e2, e3;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected parity error value once an injected word is visible
`ifdef PIPE_CTRL_PARITY_EN
  localparam logic PERR = 1'b1;
`else
  localparam logic PERR = 1'b0;
`endif

  pipe_ctrl_stage #(.WIDTH(4), .DEPTH(1), .SIDE_MASK(4'b0011)) u_d1 (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .ctrl_i(ctrl_i), .inj_i(inj_i), .valid_o(v1), .ctrl_o(c1), .occ_o(o1), .parity_err_o(e1));

  pipe_ctrl_stage #(.WIDTH(4), .DEPTH(2), .SIDE_MASK(4'b0011)) u_d2 (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .ctrl_i(ctrl_i), .inj_i(inj_i), .valid_o(v2), .ctrl_o(c2), .occ_o(o2), .parity_err_o(e2));

  pipe_ctrl_stage #(.WIDTH(4), .DEPTH(3), .SIDE_MASK(4'b0011)) u_d3 (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .ctrl_i(ctrl_i), .inj_i(inj_i), .valid_o(v3), .ctrl_o(c3), .occ_o(o3), .parity_err_o(e3));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // drive, take one rising edge, then settle past it before checking
  task automatic step(input logic v, input logic [3:0] c, input logic st, input logic fl, input logic inj);
    valid_i = v; ctrl_i = c; stall_i = st; flush_i = fl; inj_i = inj;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b1; ctrl_i = 4'hF; inj_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_v1", 32'(v1), 0);
    check("rst_c1", 32'(c1), 0);
    check("rst_o1", 32'(o1), 0);
    check("rst_e1", 32'(e1), 0);
    check("rst_c3", 32'(c3), 0);
    check("rst_o3", 32'(o3), 0);
    reset = 1'b1;

    // latency
    step(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    check("lat_c1_e1", 32'(c1), 32'hA);
    check("lat_o1_e1", 32'(o1), 1);
    check("lat_v3_e1", 32'(v3), 0);
    step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    check("lat_c2_e2", 32'(c2), 32'hA);
    check("lat_v3_e2", 32'(v3), 0);
    step(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
    check("lat_c3_e3", 32'(c3), 32'hA);
    check("lat_v3_e3", 32'(v3), 1);
    check("lat_o3_e3", 32'(o3), 3);
    check("lat_c2_e3", 32'(c2), 32'h5);

    // bubbles of 4'hF drain in behind the valid words
    step(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    check("lat_c3_e4", 32'(c3), 32'h5);
    check("bub_v1", 32'(v1), 0);
    check("bub_c1", 32'(c1), 32'hC);
    check("bub_o3_e4", 32'(o3), 2);
    step(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    check("lat_c3_e5", 32'(c3), 32'hC);
    check("bub_o3_e5", 32'(o3), 1);
    step(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
    check("bub_v3", 32'(v3), 0);
    check("bub_c3", 32'(c3), 32'hC);
    check("bub_o3", 32'(o3), 0);

    // stall on a full DEPTH=2 pipe
    step(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    check("stl_full_c2", 32'(c2), 32'hA);
    check("stl_full_o2", 32'(o2), 2);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'h3, 1'b1, 1'b0, 1'b0);
      check("stl_c2", 32'(c2), 32'hA);
      check("stl_o2", 32'(o2), 2);
      check("stl_v2", 32'(v2), 1);
    end
    step(1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    check("stl_rel1_c2", 32'(c2), 32'h5);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("stl_rel2_c2", 32'(c2), 32'h3);
    check("stl_rel2_v2", 32'(v2), 1);
    check("stl_rel2_o2", 32'(o2), 1);

    // flush wins over stall
    step(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
    check("fl_pre_o2", 32'(o2), 2);
    step(1'b1, 4'hA, 1'b1, 1'b1, 1'b0);
    check("fl_v2", 32'(v2), 0);
    check("fl_c2", 32'(c2), 32'hC);
    check("fl_o2", 32'(o2), 0);
    check("fl_o3", 32'(o3), 0);
    check("fl_c1", 32'(c1), 32'hC);

    // asynchronous reset between edges
    step(1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    check("ar_pre_v1", 32'(v1), 1);
    #2 reset = 1'b0;
    #1;
    check("ar_v1", 32'(v1), 0);
    check("ar_c1", 32'(c1), 0);
    check("ar_o2", 32'(o2), 0);
    #1 reset = 1'b1;

    // parity inject on 4'h6
    step(1'b1, 4'h6, 1'b0, 1'b0, 1'b1);
    check("par_e1", 32'(e1), 32'(PERR));
    check("par_e3_e1", 32'(e3), 0);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    check("par_e1_gone", 32'(e1), 0);
    check("par_e3_e2", 32'(e3), 0);
    step(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
    check("par_e3_e3", 32'(e3), 32'(PERR));
    check("par_c3", 32'(c3), 32'h6);
    check("par_e1_clean", 32'(e1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
